isa_cycle_master: RTL and testbench

ISA_CYCLE_MASTER -- requirements
Module: isa_cycle_master

---
 rtl/isa_master_pkg.sv | 29 ++
 rtl/isa_cycle_master_if.sv | 37 +++
 rtl/isa_wait_timer.sv | 21 ++
 rtl/isa_cycle_master.sv | 189 ++++++++++++++++++
 tb/tb_isa_cycle_master.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/isa_master_pkg.sv
// Shared types and constants for the ISA cycle master: FSM states,
// req_type encodings and the data returned on a timed-out read.
package isa_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } isa_state_e;

  localparam logic [1:0] ISA_IOR  = 2'b00;
  localparam logic [1:0] ISA_IOW  = 2'b01;
  localparam logic [1:0] ISA_MEMR = 2'b10;
  localparam logic [1:0] ISA_MEMW = 2'b11;

  localparam logic [7:0] ISA_TIMEOUT_DATA = 8'hFF;

  // Down-counters run from N-1 to 0, so a phase of N cycles loads N-1.
  function automatic logic [7:0] cyc_load(input int unsigned cyc);
    return 8'(cyc - 1);
  endfunction

  function automatic logic is_write(input logic [1:0] t);
    return t[0];
  endfunction

endpackage

// File: rtl/isa_cycle_master_if.sv
// Request/response channel and ISA bus pin group for isa_cycle_master.
// master = the side that drives the channel's primary direction.
interface isa_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;

  modport master (output req_valid, req_type, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_timeout);
  modport slave  (input  req_valid, req_type, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_timeout);
endinterface

interface isa_bus_if;
  logic [19:0] bus_a;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in;
  logic        bus_rdy;

  modport master (output bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
                         bus_aen, bus_d_out, bus_d_oe,
                  input  bus_d_in, bus_rdy);
  modport slave  (input  bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
                         bus_aen, bus_d_out, bus_d_oe,
                  output bus_d_in, bus_rdy);
endinterface

// File: rtl/isa_wait_timer.sv
// 8-bit phase down-counter shared by SETUP, STROBE, HOLD and the WAIT
// timeout; loads N-1 and stops at 0 without wrapping.
module isa_wait_timer (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)          cnt <= 8'd0;
    else if (load)         cnt <= load_val;
    else if (cnt != 8'd0)  cnt <= cnt - 8'd1;
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/isa_cycle_master.sv
// ISA bus cycle master: one IOR/IOW/MEMR/MEMW cycle per accepted request.
// Define ISA_TIMEOUT_EN to bound WAIT by TIMEOUT_CYC and flag timeouts.
//
// state     | meaning
// ST_IDLE   | bus parked (AEN=1), ready for a request, rsp_valid on entry
// ST_SETUP  | address driven, AEN=0, strobes high
// ST_STROBE | selected strobe low for STROBE_CYC cycles
// ST_WAIT   | strobe held low until bus_rdy (or timeout)
// ST_HOLD   | strobes released, address/data held
module isa_cycle_master
  import isa_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  isa_req_if.slave    req,
  isa_bus_if.master   bus
);

  if (SETUP_CYC < 1 || SETUP_CYC > 255 || STROBE_CYC < 1 || STROBE_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
    $error("isa_cycle_master: cycle parameters must be 1..255");
  end

  localparam logic [7:0] SETUP_LD  = cyc_load(SETUP_CYC);
  localparam logic [7:0] STROBE_LD = cyc_load(STROBE_CYC);
  localparam logic [7:0] HOLD_LD   = cyc_load(HOLD_CYC);
`ifdef ISA_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LD = cyc_load(TIMEOUT_CYC);
`endif

  isa_state_e  state, state_nxt;
  logic        tmr_load;
  logic [7:0]  tmr_val;
  logic        tmr_done;
  logic        accept;
  logic        rdy_hit;
  logic        finish;
  logic [1:0]  type_q;
  logic [19:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        rsp_valid_q;
  logic        in_cycle;
  logic        strobe_on;
`ifdef ISA_TIMEOUT_EN
  logic        tmo_hit;
  logic        tmo_q;
`endif

  isa_wait_timer u_timer (
    .clk      (clk),
    .reset_l  (reset_l),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = SETUP_LD;
    accept    = 1'b0;
    rdy_hit   = 1'b0;
    finish    = 1'b0;
`ifdef ISA_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (req.req_valid) begin
          accept    = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LD;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_val   = STROBE_LD;
          state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          if (bus.bus_rdy) begin
            rdy_hit   = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LD;
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_WAIT;
`ifdef ISA_TIMEOUT_EN
            tmr_load  = 1'b1;
            tmr_val   = TIMEOUT_LD;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (bus.bus_rdy) begin
          rdy_hit   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
          state_nxt = ST_HOLD;
        end
`ifdef ISA_TIMEOUT_EN
        else if (tmr_done) begin
          tmo_hit   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
          state_nxt = ST_HOLD;
        end
`endif
      end
      ST_HOLD: begin
        if (tmr_done) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      type_q      <= ISA_IOR;
      addr_q      <= 20'd0;
      wdata_q     <= 8'd0;
      rdata_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
`ifdef ISA_TIMEOUT_EN
      tmo_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= finish;
      if (accept) begin
        type_q  <= req.req_type;
        addr_q  <= req.req_addr;
        wdata_q <= req.req_wdata;
`ifdef ISA_TIMEOUT_EN
        tmo_q   <= 1'b0;
`endif
      end
      if (rdy_hit && !is_write(type_q)) rdata_q <= bus.bus_d_in;
`ifdef ISA_TIMEOUT_EN
      if (tmo_hit) begin
        tmo_q   <= 1'b1;
        rdata_q <= ISA_TIMEOUT_DATA;
      end
`endif
    end
  end

  // Strobes, AEN and OE decode straight from the async-reset state register
  // so a reset mid-cycle releases the bus without waiting for a clock.
  assign in_cycle  = (state != ST_IDLE);
  assign strobe_on = (state == ST_STROBE) || (state == ST_WAIT);

  assign req.req_ready   = (state == ST_IDLE);
  assign req.rsp_valid   = rsp_valid_q;
  assign req.rsp_rdata   = rdata_q;
`ifdef ISA_TIMEOUT_EN
  assign req.rsp_timeout = tmo_q;
`else
  assign req.rsp_timeout = 1'b0;
`endif

  assign bus.bus_a      = addr_q;
  assign bus.bus_aen    = !in_cycle;
  assign bus.bus_ior_l  = !(strobe_on && type_q == ISA_IOR);
  assign bus.bus_iow_l  = !(strobe_on && type_q == ISA_IOW);
  assign bus.bus_memr_l = !(strobe_on && type_q == ISA_MEMR);
  assign bus.bus_memw_l = !(strobe_on && type_q == ISA_MEMW);
  assign bus.bus_d_out  = wdata_q;
  assign bus.bus_d_oe   = in_cycle && is_write(type_q);

endmodule

// File: tb/tb_isa_cycle_master.sv
// Self-checking bench for isa_cycle_master: directed and random cycles
// checked against a transaction-level timing model.
module tb_isa_cycle_master;
  import isa_master_pkg::*;

  localparam int SETUP  = 2;
  localparam int STROBE = 4;
  localparam int HOLD   = 1;
  localparam int TMO    = 16;
`ifdef ISA_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int MAX_N  = 14;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int MAX_N  = 20;
`endif

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  isa_req_if rq ();
  isa_bus_if bs ();

  isa_cycle_master #(
    .SETUP_CYC   (SETUP),
    .STROBE_CYC  (STROBE),
    .HOLD_CYC    (HOLD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .req     (rq),
    .bus     (bs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bs.bus_memw_l, bs.bus_memr_l, bs.bus_iow_l, bs.bus_ior_l};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    int bad = 0;
    rq.req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (rq.rsp_valid || strobes() != 4'hF || !bs.bus_aen || bs.bus_d_oe || !rq.req_ready) bad++;
      bs.bus_rdy  = 1'($urandom);
      bs.bus_d_in = 8'($urandom);
    end
    chk({tag, " idle_bus"}, bad, 0);
  endtask

  // Expected timing comes from the phase lengths alone: the strobe lasts
  // STROBE plus the wait cycles the responder inserts (or TMO when stuck).
  task automatic run_txn(input logic [1:0] t, input logic [19:0] a, input logic [7:0] wd,
                         input int n, input logic [7:0] din, input bit stuck, input string tag);
    int waits, exp_strb, exp_lat, k, idx, strb_cnt, aen0, oe_cnt, bad, lat;
    bit done;
    logic [3:0] s, s_exp;
    waits    = stuck ? TMO : n;
    exp_strb = STROBE + waits;
    exp_lat  = SETUP + exp_strb + HOLD + 1;
    s_exp    = ~(4'b0001 << t);
    k = 0; idx = 0; strb_cnt = 0; aen0 = 0; oe_cnt = 0; bad = 0; lat = -1; done = 1'b0;

    chk({tag, " ready"}, rq.req_ready, 1);
    rq.req_valid = 1'b1;
    rq.req_type  = t;
    rq.req_addr  = a;
    rq.req_wdata = wd;
    while (!done && k < 80) begin
      step();
      k++;
      rq.req_valid = 1'b0;
      s = strobes();
      if (rq.rsp_valid) begin
        done = 1'b1;
        lat  = k;
      end
      if (s != 4'hF) begin
        strb_cnt++;
        idx++;
        if (s != s_exp) bad++;
      end
      if (!bs.bus_aen) aen0++;
      if (bs.bus_d_oe) begin
        oe_cnt++;
        if (bs.bus_d_out != wd) bad++;
      end
      if (bs.bus_a != a) bad++;
      if (!done && rq.req_ready) bad++;
      if (s != 4'hF && !stuck && idx >= STROBE + n) begin
        bs.bus_rdy  = 1'b1;
        bs.bus_d_in = din;
      end else if (s != 4'hF) begin
        bs.bus_rdy  = 1'b0;
        bs.bus_d_in = 8'($urandom);
      end else begin
        bs.bus_rdy  = 1'($urandom);
        bs.bus_d_in = 8'($urandom);
      end
    end
    chk({tag, " rsp_seen"}, done, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " strobe_len"}, strb_cnt, exp_strb);
    chk({tag, " aen_low"}, aen0, exp_lat - 1);
    chk({tag, " oe_len"}, oe_cnt, is_write(t) ? exp_lat - 1 : 0);
    chk({tag, " bus_errs"}, bad, 0);
    chk({tag, " aen_rsp"}, bs.bus_aen, 1);
    chk({tag, " timeout"}, rq.rsp_timeout, stuck);
    if (stuck || !is_write(t))
      chk({tag, " rdata"}, rq.rsp_rdata, stuck ? 8'hFF : din);
  endtask

  task automatic reset_mid_strobe();
    int k = 0;
    int rsp = 0;
    rq.req_valid = 1'b1;
    rq.req_type  = ISA_IOW;
    rq.req_addr  = 20'h12345;
    rq.req_wdata = 8'h5A;
    bs.bus_rdy   = 1'b0;
    do begin
      step();
      rq.req_valid = 1'b0;
      k++;
    end while (strobes() == 4'hF && k < 20);
    chk("rst_mid reached_strobe", strobes() != 4'hF, 1);
    #2 reset_l = 1'b0;
    #1;
    chk("rst_mid strobes", strobes(), 4'hF);
    chk("rst_mid aen", bs.bus_aen, 1);
    chk("rst_mid oe", bs.bus_d_oe, 0);
    chk("rst_mid ready", rq.req_ready, 1);
    chk("rst_mid bus_a", bs.bus_a, 0);
    @(negedge clk);
    reset_l = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rq.rsp_valid) rsp++;
    end
    chk("rst_mid no_rsp", rsp, 0);
    chk("rst_mid ready_after", rq.req_ready, 1);
  endtask

  initial begin
    rq.req_valid = 1'b0;
    rq.req_type  = 2'b00;
    rq.req_addr  = 20'd0;
    rq.req_wdata = 8'd0;
    bs.bus_rdy   = 1'b0;
    bs.bus_d_in  = 8'd0;
    #22;
    chk("reset ready", rq.req_ready, 1);
    chk("reset bus_a", bs.bus_a, 0);
    chk("reset strobes", strobes(), 4'hF);
    chk("reset aen", bs.bus_aen, 1);
    chk("reset oe", bs.bus_d_oe, 0);
    chk("reset d_out", bs.bus_d_out, 0);
    chk("reset rsp_valid", rq.rsp_valid, 0);
    chk("reset rdata", rq.rsp_rdata, 0);
    chk("reset timeout", rq.rsp_timeout, 0);
    @(negedge clk);
    reset_l = 1'b1;
    step();

    run_txn(ISA_IOW,  20'h003D8, 8'h29, 0, 8'h00, 1'b0, "iow");
    idle(2, "iow");
    run_txn(ISA_IOR,  20'h003DA, 8'h00, 0, 8'hF9, 1'b0, "ior");
    idle(1, "ior");
    run_txn(ISA_MEMR, 20'hB8000, 8'h00, 7, 8'h3C, 1'b0, "memr_wait");
    idle(1, "memr_wait");
    if (TMO_EN) begin
      run_txn(ISA_MEMW, 20'hA0010, 8'h77, 0, 8'h00, 1'b1, "memw_tmo");
      run_txn(ISA_MEMR, 20'hA0011, 8'h00, 0, 8'h42, 1'b0, "after_tmo");
      idle(1, "memw_tmo");
    end
    run_txn(ISA_IOW, 20'h00300, 8'hA1, 0, 8'h00, 1'b0, "b2b_1");
    run_txn(ISA_IOW, 20'h00301, 8'hA2, 0, 8'h00, 1'b0, "b2b_2");
    idle(1, "b2b");

    reset_mid_strobe();

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  t;
      logic [19:0] a;
      logic [7:0]  wd, din;
      int          n, gap;
      bit          stuck;
      t     = 2'($urandom_range(0, 3));
      a     = 20'($urandom);
      wd    = 8'($urandom);
      din   = 8'($urandom);
      n     = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, MAX_N);
      stuck = TMO_EN && ($urandom_range(0, 7) == 0);
      run_txn(t, a, wd, n, din, stuck, $sformatf("rnd%0d", i));
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
